// File: rtl/tag_array_sched.sv
// Port scheduler for the I-cache tag array: arbitrates lookups against refill
// writes on one single-ported macro and sweeps every set invalid after reset/flush.
module tag_array_sched #(
  parameter int SETS         = 128,
  parameter int ADDR_W       = 7,
  parameter int TAG_W        = 20,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 lk_valid,
  output logic                 lk_ready,
  input  logic [ADDR_W-1:0]    lk_addr,
  input  logic [TAG_W-2:0]     lk_tag,
  output logic                 rsp_valid,
  output logic [1:0]           rsp_hit,
  output logic [TAG_W-1:0]     rsp_tag0,
  output logic [TAG_W-1:0]     rsp_tag1,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [1:0]           wr_way,
  input  logic [TAG_W-1:0]     wr_tag,
  input  logic                 flush_req,
  output logic                 busy,
  output logic [ADDR_W-1:0]    arr_addr,
  output logic                 arr_en,
  output logic                 arr_wmode,
  output logic [2*TAG_W-1:0]   arr_wdata,
  output logic [1:0]           arr_wmask,
  input  logic [2*TAG_W-1:0]   arr_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  LIMIT    = CNT_W'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] LAST_SET = ADDR_W'(SETS - 1);

  typedef enum logic {SWEEP, RUN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]    starve_q, starve_d;
  logic                pend_q, pend_d;
  logic [TAG_W-2:0]    tag_q, tag_d;
  logic                wr_gnt, lk_gnt;
  logic [TAG_W-1:0]    rd0, rd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    starve_d  = starve_q;
    tag_d     = tag_q;
    wr_gnt    = 1'b0;
    lk_gnt    = 1'b0;
    arr_en    = 1'b0;
    arr_wmode = 1'b0;
    arr_wmask = 2'b00;
    arr_wdata = '0;
    arr_addr  = '0;

    case (state_q)
      SWEEP: begin
        arr_en    = 1'b1;
        arr_wmode = 1'b1;
        arr_wmask = 2'b11;
        arr_addr  = cnt_q;
        cnt_d     = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST_SET) state_d = RUN;
      end
      RUN: begin
        if (flush_req) begin
          cnt_d   = '0;
          state_d = SWEEP;
        end else if (!reset) begin
          // A waiting lookup only wins once the write streak hits the cap.
          wr_gnt = wr_valid && (!lk_valid || starve_q < LIMIT);
          lk_gnt = lk_valid && !wr_gnt;
        end
      end
      default: state_d = SWEEP;
    endcase

    if (wr_gnt) begin
      arr_en    = 1'b1;
      arr_wmode = 1'b1;
      arr_wmask = wr_way;
      arr_wdata = {wr_tag, wr_tag};
      arr_addr  = wr_addr;
    end
    if (lk_gnt) begin
      arr_en   = 1'b1;
      arr_addr = lk_addr;
      tag_d    = lk_tag;
    end

    if (!lk_valid || lk_gnt)
      starve_d = '0;
    else if (wr_gnt && starve_q != LIMIT)
      starve_d = starve_q + CNT_W'(1);

    pend_d = lk_gnt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= SWEEP;
      cnt_q    <= '0;
      starve_q <= '0;
      pend_q   <= 1'b0;
      tag_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      pend_q   <= pend_d;
      tag_q    <= tag_d;
    end
  end

  assign rd0 = arr_rdata[TAG_W-1:0];
  assign rd1 = arr_rdata[2*TAG_W-1:TAG_W];

  // Response fields are forced to zero whenever no lookup result is due.
  assign rsp_valid  = pend_q && !reset;
  assign rsp_tag0   = rsp_valid ? rd0 : '0;
  assign rsp_tag1   = rsp_valid ? rd1 : '0;
  assign rsp_hit[0] = rsp_valid && rd0[TAG_W-1] && (rd0[TAG_W-2:0] == tag_q);
  assign rsp_hit[1] = rsp_valid && rd1[TAG_W-1] && (rd1[TAG_W-2:0] == tag_q);

  assign lk_ready = lk_gnt;
  assign wr_ready = wr_gnt;
  assign busy     = (state_q == SWEEP) || reset;

endmodule

// File: tb/tb_tag_array_sched.sv
// Directed self-checking bench for tag_array_sched with a behavioural model
// of the single-ported tag macro (preloaded with garbage so the sweep matters).
module tb_tag_array_sched;

  logic        clock = 1'b0;
  logic        reset;
  logic        lk_valid, lk_ready;
  logic [6:0]  lk_addr;
  logic [18:0] lk_tag;
  logic        rsp_valid;
  logic [1:0]  rsp_hit;
  logic [19:0] rsp_tag0, rsp_tag1;
  logic        wr_valid, wr_ready;
  logic [6:0]  wr_addr;
  logic [1:0]  wr_way;
  logic [19:0] wr_tag;
  logic        flush_req, busy;
  logic [6:0]  arr_addr;
  logic        arr_en, arr_wmode;
  logic [39:0] arr_wdata;
  logic [1:0]  arr_wmask;
  logic [39:0] arr_rdata;

  int n_vec = 0;
  int n_err = 0;

  tag_array_sched dut (
    .clock(clock), .reset(reset),
    .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_addr(lk_addr), .lk_tag(lk_tag),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_tag0(rsp_tag0), .rsp_tag1(rsp_tag1),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_way(wr_way),
    .wr_tag(wr_tag), .flush_req(flush_req), .busy(busy),
    .arr_addr(arr_addr), .arr_en(arr_en), .arr_wmode(arr_wmode),
    .arr_wdata(arr_wdata), .arr_wmask(arr_wmask), .arr_rdata(arr_rdata)
  );

  always #5 clock = ~clock;

  // Macro model: masked writes, registered read data one cycle after a read.
  logic [39:0] mem [128];
  logic        seeded = 1'b0;
  always @(posedge clock) begin
    if (!seeded) begin
      for (int k = 0; k < 128; k++) mem[k] <= 40'hFFFFF_FFFFF ^ 40'(k);
      seeded <= 1'b1;
    end else if (arr_en) begin
      if (arr_wmode) begin
        if (arr_wmask[0]) mem[arr_addr][19:0]  <= arr_wdata[19:0];
        if (arr_wmask[1]) mem[arr_addr][39:20] <= arr_wdata[39:20];
      end else begin
        arr_rdata <= mem[arr_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks n consecutive sweep cycles starting at set 'first'; enters and leaves on a negedge.
  task automatic run_sweep(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      #1;
      chk("sweep_addr", 64'(arr_addr), 64'(i));
      chk("sweep_ctrl", {busy, arr_en, arr_wmode, arr_wmask, lk_ready, wr_ready, rsp_valid},
          8'b1111_1000);
      chk("sweep_wdata", 64'(arr_wdata), 64'd0);
      @(negedge clock);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset = 1'b1; flush_req = 1'b0;
    lk_valid = 1'b1; lk_addr = 7'd5; lk_tag = 19'd0;
    wr_valid = 1'b1; wr_addr = 7'd0; wr_way = 2'b00; wr_tag = 20'd0;

    // Reset state with both requesters asserted.
    repeat (2) @(negedge clock);
    #1;
    chk("reset_outs", {busy, lk_ready, wr_ready, rsp_valid, rsp_hit}, 6'b100000);
    chk("reset_tags", {rsp_tag1, rsp_tag0}, 40'd0);

    // Post-reset sweep, then lookup of set 5 in the first RUN cycle.
    @(negedge clock);
    reset = 1'b0; wr_valid = 1'b0;
    run_sweep(0, 128);
    #1;
    chk("run_first", {busy, lk_ready, arr_en, arr_wmode}, 4'b0110);
    chk("run_first_addr", 64'(arr_addr), 64'd5);
    @(negedge clock);
    lk_valid = 1'b0;
    #1;
    chk("set5_rsp", {rsp_valid, rsp_hit}, 3'b100);
    chk("set5_tags", {rsp_tag1, rsp_tag0}, 40'd0);

    // Write way1 of set 9.
    @(negedge clock);
    wr_valid = 1'b1; wr_addr = 7'd9; wr_way = 2'b10; wr_tag = 20'h81234;
    #1;
    chk("wr9_grant", {wr_ready, arr_en, arr_wmode, arr_wmask}, 5'b11110);
    chk("wr9_wdata", 64'(arr_wdata), 64'h81234_81234);
    chk("wr9_addr", 64'(arr_addr), 64'd9);

    // Look up set 9; the next cycle overwrites set 9 (must not bypass).
    @(negedge clock);
    wr_valid = 1'b0; lk_valid = 1'b1; lk_addr = 7'd9; lk_tag = 19'h01234;
    #1;
    chk("lk9_grant", {lk_ready, wr_ready, arr_wmode}, 3'b100);
    @(negedge clock);
    lk_valid = 1'b0;
    wr_valid = 1'b1; wr_addr = 7'd9; wr_way = 2'b11; wr_tag = 20'h85555;
    #1;
    chk("lk9_rsp", {rsp_valid, rsp_hit}, 3'b110);
    chk("lk9_tag1", 64'(rsp_tag1), 64'h81234);
    chk("lk9_tag0", 64'(rsp_tag0), 64'h0);
    chk("wr9b_grant", 64'(wr_ready), 64'd1);

    // Valid bit clear in stored tag: must miss even though the tag bits match.
    @(negedge clock);
    wr_addr = 7'd3; wr_way = 2'b01; wr_tag = 20'h01234;
    #1;
    chk("wr3_grant", {wr_ready, arr_wmask}, 3'b101);
    @(negedge clock);
    wr_valid = 1'b0; lk_valid = 1'b1; lk_addr = 7'd3; lk_tag = 19'h01234;
    #1;
    chk("lk3_grant", 64'(lk_ready), 64'd1);
    @(negedge clock);
    lk_valid = 1'b0;
    #1;
    chk("lk3_rsp", {rsp_valid, rsp_hit}, 3'b100);
    chk("lk3_tag0", 64'(rsp_tag0), 64'h01234);

    // Starvation cap: 4 writes then 1 lookup; empty mask write still granted.
    @(negedge clock);
    wr_valid = 1'b1; wr_addr = 7'd20; wr_way = 2'b00; wr_tag = 20'hFFFFF;
    lk_valid = 1'b1; lk_addr = 7'd9; lk_tag = 19'h05555;
    #1;
    chk("wr_nomask", {arr_en, arr_wmode, arr_wmask}, 4'b1100);
    for (int i = 0; i < 15; i++) begin
      #1;
      chk("starve_wr", 64'(wr_ready), 64'((i % 5) != 4));
      chk("starve_lk", 64'(lk_ready), 64'((i % 5) == 4));
      chk("starve_rsp", {rsp_valid, rsp_hit}, ((i % 5) == 0 && i > 0) ? 3'b111 : 3'b000);
      @(negedge clock);
    end

    // A cycle with lk_valid low clears the write streak.
    for (int i = 0; i < 8; i++) begin
      lk_valid = (i != 2);
      #1;
      chk("clr_wr", 64'(wr_ready), 64'(i != 7));
      chk("clr_lk", 64'(lk_ready), 64'(i == 7));
      @(negedge clock);
    end

    // Flush under traffic; a second flush mid-sweep is ignored.
    flush_req = 1'b1;
    #1;
    chk("flush_cycle", {lk_ready, wr_ready, arr_en, busy}, 4'b0000);
    @(negedge clock);
    flush_req = 1'b0;
    run_sweep(0, 50);
    flush_req = 1'b1;
    run_sweep(50, 1);
    flush_req = 1'b0;
    run_sweep(51, 77);
    wr_valid = 1'b0;
    #1;
    chk("flush_done", {busy, lk_ready, arr_wmode}, 3'b010);
    chk("flush_lk_addr", 64'(arr_addr), 64'd9);
    @(negedge clock);
    lk_valid = 1'b0;
    #1;
    chk("flush_rsp", {rsp_valid, rsp_hit}, 3'b100);
    chk("flush_tags", {rsp_tag1, rsp_tag0}, 40'd0);

    // Reset drops an in-flight lookup.
    @(negedge clock);
    lk_valid = 1'b1;
    #1;
    chk("pre_rst_lk", 64'(lk_ready), 64'd1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rst_drop", {rsp_valid, rsp_hit, busy, lk_ready}, 5'b00010);

    // Reset at sweep address 60 restarts the sweep from set 0.
    @(negedge clock);
    reset = 1'b0;
    run_sweep(0, 60);
    reset = 1'b1;
    #1;
    chk("rst60_addr", 64'(arr_addr), 64'd60);
    chk("rst60_busy", {busy, rsp_valid}, 2'b10);
    @(negedge clock);
    reset = 1'b0;
    run_sweep(0, 128);
    #1;
    chk("rst_sweep_done", {busy, lk_ready}, 2'b01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tag_array_sched.md
# tag_array_sched

Port scheduler and initializer for the I-cache tag array: 128 sets × 2 ways × 20-bit tags, behind one single-ported RW macro with a per-way write mask. It arbitrates the single port between fetch-side tag lookups and refill-side tag writes. It runs an invalidation sweep after reset and on flush. It also returns per-way hit results one cycle after each lookup.

## Interface

Parameters:
- SETS, 128, number of sets; must be 2^ADDR_W
- ADDR_W, 7, set index width
- TAG_W, 20, stored tag width; bit TAG_W-1 is the valid bit
- STARVE_LIMIT, 4, consecutive write grants allowed while a lookup waits

Ports (name, direction, width, meaning):
- clock  in  1  sole clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- lk_valid  in  1  lookup request
- lk_ready  out  1  lookup accepted this cycle
- lk_addr  in  ADDR_W  lookup set index
- lk_tag  in  TAG_W-1  compare tag
- rsp_valid  out  1  lookup result valid; no backpressure
- rsp_hit  out  2  per-way hit {way1, way0}
- rsp_tag0, rsp_tag1  out  TAG_W  raw stored tags
- wr_valid  in  1  tag write request
- wr_ready  out  1  write accepted this cycle
- wr_addr  in  ADDR_W  write set index
- wr_way  in  2  way mask; 2'b00 is accepted but performs no write
- wr_tag  in  TAG_W  tag written to each masked way
- flush_req  in  1  start an invalidation sweep
- busy  out  1  sweep in progress
- arr_addr  out  ADDR_W  macro address
- arr_en  out  1  macro enable
- arr_wmode  out  1  1 = write, 0 = read
- arr_wdata  out  2*TAG_W  {way1, way0}
- arr_wmask  out  2  {way1, way0}
- arr_rdata  in  2*TAG_W  macro read data, valid the cycle after a read enable

## Operation

- States: SWEEP and RUN. Reset enters SWEEP with sweep counter = 0.
- SWEEP behaviour:
  - Every cycle: arr_en=1, arr_wmode=1, arr_wmask=2'b11, arr_wdata=0, arr_addr=counter.
  - Counter increments each cycle; after writing set SETS-1, go to RUN.
  - busy=1; lk_ready=0; wr_ready=0.
- RUN arbitration, single grant per cycle:
  - If flush_req=1: load counter=0, go to SWEEP, grant nothing this cycle.
  - Else if a write is pending and starve_cnt<STARVE_LIMIT: grant the write.
  - Else grant a pending lookup.
  - Else if a lookup is not pending but a write is: grant the write.
- starve_cnt:
  - Increments on each write grant made while lk_valid=1.
  - Clears on any lookup grant, or on any cycle with lk_valid=0.
  - Saturates at STARVE_LIMIT.
- Write grant: arr_en=1, arr_wmode=1, arr_wmask=wr_way, arr_wdata={wr_tag,wr_tag}, arr_addr=wr_addr.
- Lookup grant:
  - arr_en=1, arr_wmode=0, arr_addr=lk_addr.
  - lk_tag and a pending flag are registered.
- Idle cycle: arr_en=0, all other array outputs 0.
- Hit rule, per way: rsp_hit[w] = tagw[TAG_W-1] && tagw[TAG_W-2:0]==registered lk_tag.
- No read/write bypass: a lookup returns the array contents at its read cycle. A write granted in the cycle after a lookup does not affect that lookup's response.
- flush_req while busy is ignored; the current sweep continues.
- Reset asserted mid-sweep restarts the sweep at set 0. Reset drops any in-flight lookup, so rsp_valid=0 in the next cycle.

## Timing

- lk_ready and wr_ready are combinational from the valids and state. Array outputs are driven combinationally in the grant cycle.
- Lookup latency is 1: a grant in cycle N gives rsp_valid=1 in cycle N+1, with rsp_tag0=arr_rdata[TAG_W-1:0] and rsp_tag1=arr_rdata[2*TAG_W-1:TAG_W].
- Sweep length is exactly SETS cycles. busy deasserts in the first RUN cycle, and grants are possible in that same cycle.
- Flush latency: flush_req in cycle N → busy=1 from cycle N+1 for SETS cycles.
- Output values during reset and in the cycle after reset:
  - rsp_valid=0, rsp_hit=0, rsp_tag0=0, rsp_tag1=0.
  - lk_ready=0, wr_ready=0.
  - busy=1.
- Throughput: one array operation per cycle. Back-to-back lookups produce one response per cycle.

## Test plan

- Reset sweep: release reset → busy=1 for 128 cycles. The array sees writes with wdata=0, wmask=2'b11 at addresses 0..127. Then a lookup to set 5 returns rsp_hit=2'b00 and both tags 0.
- Write then hit: write set 9, way 2'b10, tag 20'h8_1234; then look up set 9 with lk_tag=19'h1234 → rsp_hit=2'b10 one cycle after grant, rsp_tag1=20'h81234.
- Starvation cap: hold wr_valid and lk_valid high together → grant pattern is 4 writes, 1 lookup, repeating. starve_cnt never exceeds 4.
- Invalid-bit miss: write tag 20'h0_1234 to way 0 of set 3; look up with lk_tag=19'h1234 → rsp_hit=2'b00.
- Flush under traffic: assert flush_req in RUN with both requesters active → no grant that cycle, busy=1 for 128 cycles, lk_ready=wr_ready=0 throughout. A flush_req during the sweep does not extend it.
- Reset mid-sweep: assert reset at sweep address 60 → the sweep restarts at address 0 and runs the full 128 cycles. rsp_valid stays 0.
